gpc_accum: RTL
==============

GPC_ACCUM -- requirements
Module: gpc_accum

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 16: beats per frame, range 1..255.
REQ-002 SHALL have parameter SUM_W, default 8: width of the accumulated sum, range 4..16.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1: clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: synchronous active-high reset.
REQ-006 SHALL have port in_cnt  input  3: one beat's count, taken from a gpc6_3 dst output (legal range 0..6).
REQ-007 SHALL have port in_valid  input  1: in_cnt and in_last are valid.
REQ-008 SHALL have port in_last  input  1: this beat closes the frame early.
REQ-009 SHALL have port in_ready  output  1: block can accept a beat.
REQ-010 SHALL have port out_sum  output  SUM_W: frame total.
REQ-011 SHALL have port out_beats  output  8: number of beats accepted in the frame.
REQ-012 SHALL have port out_ovf  output  1: frame total exceeded 2^SUM_W-1.
REQ-013 SHALL have port out_valid  output  1: the out_* result is valid.
REQ-014 SHALL have port out_ready  input  1: downstream accepts the result.

Function
REQ-015 SHALL implement two states: ACCUM (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-016 SHALL accept a beat when in_valid && in_ready; a beat accepted in ACCUM adds in_cnt to the accumulator and increments the beat counter.
REQ-017 SHALL clamp an accepted in_cnt of 7 to 6 before adding it.
REQ-018 SHALL go from ACCUM to DONE on the accepted beat that is the FRAME_LEN-th beat of the frame, or that has in_last=1, whichever comes first.
REQ-019 SHALL assert out_valid in the cycle after the closing beat is accepted; out_sum SHALL include the closing beat (latency 1 cycle).
REQ-020 SHALL hold out_sum, out_beats, out_ovf and out_valid stable in DONE while out_ready=0.
REQ-021 SHALL return from DONE to ACCUM in the cycle after out_valid && out_ready, with the accumulator, beat count and ovf cleared; the result slot is single, so there is a one-cycle input bubble per frame.
REQ-022 SHALL ignore in_valid, in_cnt and in_last while in DONE.
REQ-023 SHALL, with SUM_W bits, set the ovf flag when any addition carries out of bit SUM_W-1; the flag is sticky for the frame.
REQ-024 SHALL drive out_sum, out_beats and out_ovf to 0 whenever out_valid=0.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, enter ACCUM with accumulator=0, beat count=0, ovf=0, out_valid=0 and in_ready=1 in the following cycle.
REQ-026 SHALL, on reset mid-frame or in DONE, discard the partial or pending result; no out_valid pulse follows.
REQ-027 SHALL hold in_ready=1 during the reset cycle's output, but SHALL not count a beat presented while rst=1.

Configuration
REQ-028 SHALL, with macro GPC_ACCUM_SAT_EN defined, saturate the accumulator at 2^SUM_W-1 on overflow, with out_ovf=1.
REQ-029 SHALL, without GPC_ACCUM_SAT_EN, wrap the accumulator modulo 2^SUM_W on overflow, with out_ovf=1; all other behaviour is identical.

Verification
REQ-030 SHALL cover a full frame at FRAME_LEN=16, SUM_W=8 with 16 beats of in_cnt=6 and out_ready=1 -> one cycle later out_valid=1, out_sum=96, out_beats=16, out_ovf=0; in_ready=1 again two cycles after the last beat.
REQ-031 SHALL cover early last with beats 2, 3, 1 and in_last=1 on the third -> out_sum=6, out_beats=3, out_ovf=0.
REQ-032 SHALL cover overflow at SUM_W=6, FRAME_LEN=16 with 16 beats of 6 -> with GPC_ACCUM_SAT_EN: out_sum=63, out_ovf=1; without it: out_sum=32, out_ovf=1.
REQ-033 SHALL cover backpressure with out_ready=0 for 5 cycles in DONE while in_valid=1 -> out_sum stays stable, in_ready=0, no beats counted; out_ready=1 -> next frame starts with the accumulator at 0.
REQ-034 SHALL cover reset mid-frame with rst pulsed after 5 beats of 4 -> no out_valid pulse; a following 2-beat frame of 1, 1 with in_last gives out_sum=2, out_beats=2.
REQ-035 SHALL cover an illegal count with a 1-beat frame of in_cnt=7 and in_last=1 -> out_sum=6.

Source files
------------

// File: rtl/gpc_accum.sv
// Frame accumulator for gpc6_3 counts: sums beats until FRAME_LEN or in_last, then holds one result.
// Optional macro GPC_ACCUM_SAT_EN: saturate the sum on overflow instead of wrapping.
module gpc_accum #(
  parameter int FRAME_LEN = 16,
  parameter int SUM_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       in_cnt,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [7:0]       out_beats,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {ACCUM, DONE} state_t;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic [7:0]       beats;
    logic             ovf;
  } res_t;

  state_t     state, state_nxt;
  res_t       res, res_nxt;
  logic [2:0] cnt_c;
  logic [SUM_W:0] add;
  logic       take;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      res   <= '0;
    end else begin
      state <= state_nxt;
      res   <= res_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    res_nxt   = res;
    // 7 is not a legal gpc6_3 count; treat it as the maximum legal value
    cnt_c     = (in_cnt == 3'd7) ? 3'd6 : in_cnt;
    add       = {1'b0, res.sum} + {{(SUM_W-2){1'b0}}, cnt_c};
    take      = in_valid && (state == ACCUM);
    case (state)
      ACCUM: begin
        if (take) begin
          res_nxt.beats = res.beats + 8'd1;
          res_nxt.ovf   = res.ovf | add[SUM_W];
`ifdef GPC_ACCUM_SAT_EN
          res_nxt.sum   = add[SUM_W] ? '1 : add[SUM_W-1:0];
`else
          res_nxt.sum   = add[SUM_W-1:0];
`endif
          if (in_last || (res_nxt.beats == 8'(FRAME_LEN)))
            state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = ACCUM;
          res_nxt   = '0;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // in_ready stays high while rst is asserted; the reset branch still drops the beat
  assign in_ready  = (state == ACCUM) || rst;
  assign out_valid = (state == DONE);
  assign out_sum   = out_valid ? res.sum   : '0;
  assign out_beats = out_valid ? res.beats : 8'd0;
  assign out_ovf   = out_valid ? res.ovf   : 1'b0;

endmodule
